ps2_keyboard_rx: RTL and testbench



---
 rtl/ps2_keyboard_rx_pkg.sv | 34 +++
 rtl/ps2_keyboard_rx_line_filter.sv | 55 +++++
 rtl/ps2_keyboard_rx.sv | 177 +++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keyboard_rx_pkg.sv
// ps2_keyboard_rx_pkg
// Shared constants for the PS/2 keyboard receiver: prefix bytes, the list of
// keyboard status bytes that are dropped when no prefix is pending, and the
// deframer state encoding (kept here so a bench can probe the state).
package ps2_keyboard_rx_pkg;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

    // Status / acknowledge bytes sent by the keyboard, packed 8 bits each.
    localparam int              PS2_NUM_STATUS   = 6;
    localparam logic [6*8-1:0]  PS2_STATUS_LIST  = {8'h00, 8'hAA, 8'hFA,
                                                    8'hEE, 8'hFE, 8'hFF};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    function automatic logic is_status_byte(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < PS2_NUM_STATUS; i++) begin
            if (PS2_STATUS_LIST[i*8 +: 8] == b) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_line_filter.sv
// ps2_line_filter
// Brings one raw PS/2 line into the clock domain (2-FF synchroniser) and
// debounces it: the filtered level only changes after FILTER consecutive
// synchronised samples that differ from it.
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   raw    in   raw asynchronous line
//   level  out  filtered line level (resets to 1, the idle bus level)
//   fall   out  one-cycle pulse in the cycle level goes 1 -> 0
module ps2_line_filter #(
    parameter int FILTER = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int             CW       = (FILTER < 2) ? 1 : $clog2(FILTER);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            cnt_reg   <= '0;
            level     <= 1'b1;
            fall      <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            fall      <= 1'b0;
            if (sync2_reg != level) begin
                // cnt_reg counts differing samples already seen; this one is
                // the FILTER-th when the count is at its last value.
                if (cnt_reg == CNT_LAST) begin
                    level   <= sync2_reg;
                    fall    <= level & ~sync2_reg;
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
// PS/2 keyboard receiver (device-to-host only). Filters the raw clock/data
// lines, deframes 11-bit frames (start, 8 data LSB first, odd parity, stop)
// on filtered ps2Ck falling edges, and folds E0/F0 prefixes into single key
// events for the keyboard matrix block.
// Ports:
//   clock  in   system clock (clock32), rising edge
//   reset  in   asynchronous active-low reset
//   ps2Ck  in   raw PS/2 clock line
//   ps2D   in   raw PS/2 data line
//   strb   out  one-cycle key event strobe
//   make   out  1 = press, 0 = release (held until next strb)
//   code   out  set-2 scan code without prefixes (held until next strb)
//   ext    out  event was E0-prefixed (held until next strb)
//   err    out  one-cycle pulse on start/parity/stop/timeout error
module ps2_keyboard_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 32000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Ck,
    input  logic       ps2D,
    output logic       strb,
    output logic       make,
    output logic [7:0] code,
    output logic       ext,
    output logic       err
);

    localparam int             TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT);

    logic ck_level;
    logic ck_fall;
    logic d_level;

    // The clock line's level itself is not needed, only its falling edge.
    ps2_line_filter #(.FILTER(FILTER)) u_ck_filter (
        .clock (clock),
        .reset (reset),
        .raw   (ps2Ck),
        .level (ck_level),
        .fall  (ck_fall)
    );

    // Data is only ever sampled on clock edges, so its edge output is unused.
    ps2_line_filter #(.FILTER(FILTER)) u_d_filter (
        .clock (clock),
        .reset (reset),
        .raw   (ps2D),
        .level (d_level),
        .fall  ()
    );

    // ------------------------------------------------------------------
    // Deframer
    // ------------------------------------------------------------------
    ps2_state_e    state_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic          parity_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic          byte_valid_reg;
    logic          frame_err_reg;   // start/parity/stop error: drops prefixes
    logic          tmo_err_reg;     // timeout: prefixes survive

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            parity_reg     <= 1'b0;
            tmo_cnt_reg    <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            tmo_err_reg    <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            tmo_err_reg    <= 1'b0;
            if (ck_fall) begin
                tmo_cnt_reg <= '0;
                case (state_reg)
                    ST_IDLE: begin
                        if (!d_level) begin
                            state_reg   <= ST_DATA;
                            bit_cnt_reg <= '0;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shift_reg <= {d_level, shift_reg[7:1]};
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= ST_PARITY;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        parity_reg <= d_level;
                        state_reg  <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (d_level && (^{shift_reg, parity_reg})) begin
                            byte_valid_reg <= 1'b1;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                        state_reg   <= ST_IDLE;
                        bit_cnt_reg <= '0;
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end else if (state_reg != ST_IDLE) begin
                if (tmo_cnt_reg == TMO_LAST) begin
                    tmo_err_reg <= 1'b1;
                    state_reg   <= ST_IDLE;
                    bit_cnt_reg <= '0;
                    tmo_cnt_reg <= '0;
                end else begin
                    tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                end
            end else begin
                tmo_cnt_reg <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte decoder: prefix tracking and event generation
    // ------------------------------------------------------------------
    logic ext_pend_reg;
    logic brk_pend_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            strb         <= 1'b0;
            make         <= 1'b0;
            code         <= 8'h00;
            ext          <= 1'b0;
            err          <= 1'b0;
            ext_pend_reg <= 1'b0;
            brk_pend_reg <= 1'b0;
        end else begin
            strb <= 1'b0;
            // byte_valid and the error pulses are mutually exclusive, so
            // strb and err can never coincide.
            err  <= frame_err_reg | tmo_err_reg;
            if (frame_err_reg) begin
                ext_pend_reg <= 1'b0;
                brk_pend_reg <= 1'b0;
            end else if (byte_valid_reg) begin
                if (shift_reg == PS2_PFX_EXT) begin
                    ext_pend_reg <= 1'b1;
                end else if (shift_reg == PS2_PFX_BRK) begin
                    brk_pend_reg <= 1'b1;
                end else if (shift_reg == PS2_PFX_PAUSE) begin
                    // Pause then decodes as plain 14/77 events.
                end else if (is_status_byte(shift_reg) && !ext_pend_reg && !brk_pend_reg) begin
                    // Keyboard status byte outside a prefixed sequence.
                end else begin
                    strb         <= 1'b1;
                    code         <= shift_reg;
                    make         <= ~brk_pend_reg;
                    ext          <= ext_pend_reg;
                    ext_pend_reg <= 1'b0;
                    brk_pend_reg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx
// Drives PS/2 frames into ps2_keyboard_rx and compares event/error counts and
// held outputs with a byte-level model of the prefix rules.
module tb_ps2_keyboard_rx;
    import ps2_keyboard_rx_pkg::*;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 1000;   // shortened to keep the run brief
    localparam int HALF    = 24;     // clock cycles per PS/2 half bit

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ps2Ck = 1'b1;
    logic       ps2D  = 1'b1;
    logic       strb;
    logic       make;
    logic [7:0] code;
    logic       ext;
    logic       err;

    always #5 clock = ~clock;

    ps2_keyboard_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .ps2Ck (ps2Ck),
        .ps2D  (ps2D),
        .strb  (strb),
        .make  (make),
        .code  (code),
        .ext   (ext),
        .err   (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: counts strobes, error pulses and illegal overlaps.
    int obs_strb = 0;
    int obs_err  = 0;
    int obs_both = 0;
    always @(negedge clock) begin
        if (strb)        obs_strb <= obs_strb + 1;
        if (err)         obs_err  <= obs_err + 1;
        if (strb && err) obs_both <= obs_both + 1;
    end

    // Reference model: pending prefixes and expected held outputs.
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    int         exp_strb = 0;
    int         exp_err  = 0;
    logic [7:0] exp_code = 8'h00;
    logic       exp_make = 1'b0;
    logic       exp_ext  = 1'b0;

    function automatic logic tb_is_status(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFF: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    task automatic model_frame(input logic [7:0] b, input logic good);
        if (!good) begin
            exp_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE1) begin
            // ignored
        end else if (tb_is_status(b) && !m_ext && !m_brk) begin
            // dropped
        end else begin
            exp_strb++;
            exp_code = b;
            exp_make = ~m_brk;
            exp_ext  = m_ext;
            m_ext    = 1'b0;
            m_brk    = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_ext    = 1'b0;
        m_brk    = 1'b0;
        exp_code = 8'h00;
        exp_make = 1'b0;
        exp_ext  = 1'b0;
    endtask

    // Sends the first n bits of a frame (bit 0 first); line ends high.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            ps2D = bits[i];
            repeat (HALF) @(negedge clock);
            ps2Ck = 1'b0;
            repeat (HALF) @(negedge clock);
            ps2Ck = 1'b1;
        end
        ps2D = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        send_bits({~bad_stop, par, b, 1'b0}, 11);
        model_frame(b, !bad_par && !bad_stop);
        repeat (30) @(negedge clock);
    endtask

    task automatic check_events(input string tag);
        check({tag, " strb count"}, obs_strb, exp_strb);
        check({tag, " err count"},  obs_err,  exp_err);
        check({tag, " code"}, int'(code), int'(exp_code));
        check({tag, " make"}, int'(make), int'(exp_make));
        check({tag, " ext"},  int'(ext),  int'(exp_ext));
    endtask

    task automatic frame_and_check(input string tag, input logic [7:0] b,
                                   input logic bad_par, input logic bad_stop);
        send_frame(b, bad_par, bad_stop);
        check_events(tag);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rpar;
        logic       rstop;
        int         r;
        logic [47:0] status_list;
        status_list = {8'h00, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFF};

        // Reset state
        repeat (5) @(negedge clock);
        check("reset strb", int'(strb), 0);
        check("reset err",  int'(err),  0);
        check("reset code", int'(code), 0);
        check("reset state", int'(dut.state_reg), int'(ST_IDLE));
        reset = 1'b1;
        repeat (5) @(negedge clock);

        // 1: plain press
        frame_and_check("t1 1C", 8'h1C, 1'b0, 1'b0);
        // 2: release
        frame_and_check("t2 F0", 8'hF0, 1'b0, 1'b0);
        frame_and_check("t2 1C", 8'h1C, 1'b0, 1'b0);
        // 3: extended release then plain press
        frame_and_check("t3 E0", 8'hE0, 1'b0, 1'b0);
        frame_and_check("t3 F0", 8'hF0, 1'b0, 1'b0);
        frame_and_check("t3 75", 8'h75, 1'b0, 1'b0);
        frame_and_check("t3 75b", 8'h75, 1'b0, 1'b0);
        // 4: parity error clears a pending break
        frame_and_check("t4 F0", 8'hF0, 1'b0, 1'b0);
        frame_and_check("t4 badpar", 8'h1C, 1'b1, 1'b0);
        frame_and_check("t4 1C", 8'h1C, 1'b0, 1'b0);
        frame_and_check("t4 badstop", 8'h33, 1'b0, 1'b1);

        // 5: timeout mid-frame; a pending break survives it
        frame_and_check("t5 F0", 8'hF0, 1'b0, 1'b0);
        send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
        repeat (TIMEOUT + 10) @(negedge clock);
        exp_err++;
        check("t5 timeout err", obs_err, exp_err);
        check("t5 timeout state", int'(dut.state_reg), int'(ST_IDLE));
        frame_and_check("t5 29", 8'h29, 1'b0, 1'b0);

        // 6: status byte alone, then a prefixed status byte
        frame_and_check("t6 AA", 8'hAA, 1'b0, 1'b0);
        frame_and_check("t6 E0", 8'hE0, 1'b0, 1'b0);
        frame_and_check("t6 E0 AA", 8'hAA, 1'b0, 1'b0);
        frame_and_check("t6 E1", 8'hE1, 1'b0, 1'b0);

        // 6: sub-threshold glitches on ps2Ck while idle
        for (int g = 0; g < 4; g++) begin
            @(negedge clock);
            ps2Ck = 1'b0;
            repeat (FILTER - 1) @(negedge clock);
            ps2Ck = 1'b1;
            repeat (FILTER + 4) @(negedge clock);
        end
        check("t6 glitch state", int'(dut.state_reg), int'(ST_IDLE));
        check_events("t6 glitch");

        // 6: reset mid-DATA with a break pending
        frame_and_check("t6 F0", 8'hF0, 1'b0, 1'b0);
        send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 4);
        reset = 1'b0;
        #1;
        model_reset();
        check("t6 rst code", int'(code), 0);
        check("t6 rst strb", int'(strb), 0);
        check("t6 rst state", int'(dut.state_reg), int'(ST_IDLE));
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check_events("t6 after reset");
        frame_and_check("t6 1C after reset", 8'h1C, 1'b0, 1'b0);

        // Randomised frames
        for (int k = 0; k < 36; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       rb = 8'hE0;
                1:       rb = 8'hF0;
                2:       rb = 8'hE1;
                3:       rb = status_list[$urandom_range(0, 5)*8 +: 8];
                default: rb = 8'($urandom);
            endcase
            r     = $urandom_range(0, 11);
            rpar  = (r == 0);
            rstop = (r == 1);
            frame_and_check($sformatf("rnd%0d %02h", k, rb), rb, rpar, rstop);
        end

        check("strb/err overlap", obs_both, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
